// File: rtl/gpio_irq_unit_if.sv
// rtl/gpio_irq_unit_if.sv - per-pin event inputs, irq configuration and status outputs of gpio_irq_unit
interface gpio_irq_unit_if #(
  parameter int unsigned NrGpios = 32
) ();
  logic [NrGpios-1:0]      gpio_en_i;
  logic [NrGpios-1:0]      r_edge_i;
  logic [NrGpios-1:0]      f_edge_i;
  logic [NrGpios-1:0]      level_i;
  logic [NrGpios-1:0]      irq_en_i;
  logic [NrGpios-1:0][2:0] irq_type_i;
  logic [NrGpios-1:0]      clr_i;
  logic [NrGpios-1:0]      pending_o;
  logic [NrGpios-1:0]      missed_o;
  logic                    irq_o;
  logic                    irq_pulse_o;

  modport master (
    output gpio_en_i, r_edge_i, f_edge_i, level_i, irq_en_i, irq_type_i, clr_i,
    input  pending_o, missed_o, irq_o, irq_pulse_o
  );

  modport slave (
    input  gpio_en_i, r_edge_i, f_edge_i, level_i, irq_en_i, irq_type_i, clr_i,
    output pending_o, missed_o, irq_o, irq_pulse_o
  );
endinterface

// File: rtl/gpio_irq_unit.sv
// rtl/gpio_irq_unit.sv - per-pin sticky interrupt pending/missed status with aggregated irq line
module gpio_irq_unit #(
  parameter int unsigned NrGpios = 32
) (
  input logic           clk,
  input logic           rst_ni,
  gpio_irq_unit_if.slave bus
);

  localparam logic [2:0] ModeRise = 3'b000;
  localparam logic [2:0] ModeFall = 3'b001;
  localparam logic [2:0] ModeBoth = 3'b010;
  localparam logic [2:0] ModeHigh = 3'b011;
  localparam logic [2:0] ModeLow  = 3'b100;

  logic [NrGpios-1:0] mode_hit;
  logic [NrGpios-1:0] edge_mode;
  logic [NrGpios-1:0] trig;
  logic [NrGpios-1:0] pending_d, pending_q;
  logic [NrGpios-1:0] missed_d, missed_q;
  logic               irq;
  logic               irq_q;

  // Reserved encodings leave mode_hit low so those pins can never fire.
  always_comb begin
    mode_hit  = '0;
    edge_mode = '0;
    for (int unsigned i = 0; i < NrGpios; i++) begin
      case (bus.irq_type_i[i])
        ModeRise: begin
          mode_hit[i]  = bus.r_edge_i[i];
          edge_mode[i] = 1'b1;
        end
        ModeFall: begin
          mode_hit[i]  = bus.f_edge_i[i];
          edge_mode[i] = 1'b1;
        end
        ModeBoth: begin
          mode_hit[i]  = bus.r_edge_i[i] | bus.f_edge_i[i];
          edge_mode[i] = 1'b1;
        end
        ModeHigh: mode_hit[i] = bus.level_i[i];
        ModeLow:  mode_hit[i] = ~bus.level_i[i];
        default:  mode_hit[i] = 1'b0;
      endcase
    end
  end

  assign trig = bus.gpio_en_i & bus.irq_en_i & mode_hit;

  // A trigger beats a simultaneous clear; a clear in the same cycle as a
  // re-trigger is treated as acknowledging the old event, not a miss.
  assign pending_d = trig | (pending_q & ~bus.clr_i);
  assign missed_d  = (trig & pending_q & edge_mode & ~bus.clr_i) | (missed_q & ~bus.clr_i);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      missed_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      missed_q  <= missed_d;
      irq_q     <= irq;
    end
  end

  assign irq             = |pending_q;
  assign bus.pending_o   = pending_q;
  assign bus.missed_o    = missed_q;
  assign bus.irq_o       = irq;
  assign bus.irq_pulse_o = irq & ~irq_q;

endmodule

// File: tb/tb_gpio_irq_unit.sv
// tb/tb_gpio_irq_unit.sv - directed scoreboard bench for gpio_irq_unit
module tb_gpio_irq_unit;
  localparam int unsigned NR = 16;

  typedef struct {
    string         tag;
    logic [NR-1:0] pend;
    logic [NR-1:0] miss;
    logic          irq;
    logic          pulse;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   total = 0;
  int   passed = 0;
  exp_t sb[$];

  gpio_irq_unit_if #(.NrGpios(NR)) bus ();

  gpio_irq_unit #(.NrGpios(NR)) dut (
    .clk    (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NR-1:0] obs, input logic [NR-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic exp_nxt(input string tag, input logic [NR-1:0] p, input logic [NR-1:0] m,
                         input logic i, input logic u);
    exp_t e;
    e.tag   = tag;
    e.pend  = p;
    e.miss  = m;
    e.irq   = i;
    e.pulse = u;
    sb.push_back(e);
  endtask

  // Advance one clock, score every queued expectation, then drop one-cycle strobes.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".pending"}, bus.pending_o, e.pend);
      chk({e.tag, ".missed"}, bus.missed_o, e.miss);
      chk({e.tag, ".irq"}, {{(NR-1){1'b0}}, bus.irq_o}, {{(NR-1){1'b0}}, e.irq});
      chk({e.tag, ".pulse"}, {{(NR-1){1'b0}}, bus.irq_pulse_o}, {{(NR-1){1'b0}}, e.pulse});
    end
    bus.r_edge_i = '0;
    bus.f_edge_i = '0;
    bus.clr_i    = '0;
  endtask

  initial begin
    bus.gpio_en_i  = '1;
    bus.irq_en_i   = '1;
    bus.r_edge_i   = '0;
    bus.f_edge_i   = '0;
    bus.level_i    = '0;
    bus.clr_i      = '0;
    bus.irq_type_i = '0;
    tick();
    tick();
    rst_ni = 1'b1;
    exp_nxt("reset", '0, '0, 1'b0, 1'b0);
    tick();

    // Rising edge on pin 3
    for (int k = 0; k < 5; k++) tick();
    bus.r_edge_i[3] = 1'b1;
    exp_nxt("rise3_set", 16'h0008, '0, 1'b1, 1'b1);
    tick();
    exp_nxt("rise3_hold", 16'h0008, '0, 1'b1, 1'b0);
    tick();
    bus.clr_i[3] = 1'b1;
    exp_nxt("rise3_clr", '0, '0, 1'b0, 1'b0);
    tick();

    // Set beats clear on pin 0, and the re-trigger is not counted as a miss
    bus.r_edge_i[0] = 1'b1;
    exp_nxt("p0_set", 16'h0001, '0, 1'b1, 1'b1);
    tick();
    bus.r_edge_i[0] = 1'b1;
    bus.clr_i[0]    = 1'b1;
    exp_nxt("p0_set_clr", 16'h0001, '0, 1'b1, 1'b0);
    tick();
    bus.clr_i[0] = 1'b1;
    exp_nxt("p0_clr", '0, '0, 1'b0, 1'b0);
    tick();

    // Both-edge mode on pin 5: simultaneous edges count once, then a miss
    bus.irq_type_i[5] = 3'b010;
    bus.r_edge_i[5]   = 1'b1;
    bus.f_edge_i[5]   = 1'b1;
    exp_nxt("p5_dual", 16'h0020, '0, 1'b1, 1'b1);
    tick();
    bus.f_edge_i[5] = 1'b1;
    exp_nxt("p5_miss", 16'h0020, 16'h0020, 1'b1, 1'b0);
    tick();
    exp_nxt("p5_miss_hold", 16'h0020, 16'h0020, 1'b1, 1'b0);
    tick();
    bus.clr_i[5] = 1'b1;
    exp_nxt("p5_clr", '0, '0, 1'b0, 1'b0);
    tick();

    // Level-high on pin 7 re-asserts through a clear
    bus.irq_type_i[7] = 3'b011;
    bus.level_i[7]    = 1'b1;
    exp_nxt("p7_lvl", 16'h0080, '0, 1'b1, 1'b1);
    tick();
    bus.clr_i[7] = 1'b1;
    exp_nxt("p7_clr_lvl", 16'h0080, '0, 1'b1, 1'b0);
    tick();
    bus.level_i[7] = 1'b0;
    bus.clr_i[7]   = 1'b1;
    exp_nxt("p7_clr", '0, '0, 1'b0, 1'b0);
    tick();

    // Level-low on pin 8
    bus.irq_type_i[8] = 3'b100;
    bus.level_i[8]    = 1'b1;
    exp_nxt("p8_high", '0, '0, 1'b0, 1'b0);
    tick();
    bus.level_i[8] = 1'b0;
    exp_nxt("p8_low", 16'h0100, '0, 1'b1, 1'b1);
    tick();
    bus.level_i[8] = 1'b1;
    bus.clr_i[8]   = 1'b1;
    exp_nxt("p8_clr", '0, '0, 1'b0, 1'b0);
    tick();

    // Pin 2 gating and reserved mode
    bus.gpio_en_i[2] = 1'b0;
    bus.r_edge_i[2]  = 1'b1;
    exp_nxt("p2_gpio_off", '0, '0, 1'b0, 1'b0);
    tick();
    bus.gpio_en_i[2] = 1'b1;
    bus.irq_en_i[2]  = 1'b0;
    bus.r_edge_i[2]  = 1'b1;
    exp_nxt("p2_irq_off", '0, '0, 1'b0, 1'b0);
    tick();
    bus.irq_en_i[2]   = 1'b1;
    bus.irq_type_i[2] = 3'b110;
    bus.level_i[2]    = 1'b1;
    bus.r_edge_i[2]   = 1'b1;
    bus.f_edge_i[2]   = 1'b1;
    exp_nxt("p2_reserved", '0, '0, 1'b0, 1'b0);
    tick();
    bus.level_i[2] = 1'b0;
    exp_nxt("p2_reserved_lo", '0, '0, 1'b0, 1'b0);
    tick();
    bus.irq_type_i[2] = 3'b000;
    bus.r_edge_i[2]   = 1'b1;
    exp_nxt("p2_set", 16'h0004, '0, 1'b1, 1'b1);
    tick();
    bus.irq_en_i[2]  = 1'b0;
    bus.irq_type_i[2] = 3'b001;
    exp_nxt("p2_en_off_hold", 16'h0004, '0, 1'b1, 1'b0);
    tick();
    bus.gpio_en_i[2] = 1'b0;
    bus.clr_i[2]     = 1'b1;
    exp_nxt("p2_clr_gated", '0, '0, 1'b0, 1'b0);
    tick();
    bus.gpio_en_i[2]  = 1'b1;
    bus.irq_en_i[2]   = 1'b1;
    bus.irq_type_i[2] = 3'b000;

    // Asynchronous reset with pins 1 and 9 pending
    bus.r_edge_i[1] = 1'b1;
    bus.r_edge_i[9] = 1'b1;
    exp_nxt("p1_9_set", 16'h0202, '0, 1'b1, 1'b1);
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst.pending", bus.pending_o, '0);
    chk("async_rst.missed", bus.missed_o, '0);
    chk("async_rst.irq", {{(NR-1){1'b0}}, bus.irq_o}, '0);
    chk("async_rst.pulse", {{(NR-1){1'b0}}, bus.irq_pulse_o}, '0);
    bus.r_edge_i[1] = 1'b1;
    exp_nxt("rst_edge_lost", '0, '0, 1'b0, 1'b0);
    tick();
    #2;
    rst_ni = 1'b1;
    bus.r_edge_i[9] = 1'b1;
    exp_nxt("post_rst_set", 16'h0200, '0, 1'b1, 1'b1);
    tick();
    exp_nxt("post_rst_hold", 16'h0200, '0, 1'b1, 1'b0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
